grf_trace_collector: RTL and testbench

- Consumes the GRF write-trace stream produced by the CPU register file (we / addr / wdata / inst_addr) and buffers each committed register write in a FIFO.
- Drains the buffered records through a valid/ready port to the testbench logger or a UART dumper.
- Tags every event with a sequence number and counts events dropped on overflow, so the log consumer can detect gaps.

---
 rtl/grf_trace_collector_pkg.sv | 33 +++
 rtl/grf_trace_collector_if.sv | 36 +++
 rtl/grf_trace_collector_sync_fifo_core.sv | 50 +++++
 rtl/grf_trace_collector.sv | 77 +++++++
 tb/tb_grf_trace_collector.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/grf_trace_collector_pkg.sv
// Shared record layout for the GRF write-trace path: field widths and bit offsets
// used by the collector to pack records and by the UART dumper to unpack them.
package grf_trace_collector_pkg;

  localparam int PC_W      = 32;
  localparam int ADDR_W    = 5;
  localparam int DATA_W    = 32;
  localparam int SEQ_W_DEF = 16;

  // Record layout, LSB first: seq | wdata | addr | pc
  localparam int TRACE_W   = PC_W + ADDR_W + DATA_W + SEQ_W_DEF;
  localparam int OFF_SEQ   = 0;
  localparam int OFF_WDATA = SEQ_W_DEF;
  localparam int OFF_ADDR  = OFF_WDATA + DATA_W;
  localparam int OFF_PC    = OFF_ADDR + ADDR_W;

  function automatic int trace_w(input int seq_w);
    return PC_W + ADDR_W + DATA_W + seq_w;
  endfunction

  function automatic int off_wdata(input int seq_w);
    return seq_w;
  endfunction

  function automatic int off_addr(input int seq_w);
    return seq_w + DATA_W;
  endfunction

  function automatic int off_pc(input int seq_w);
    return seq_w + DATA_W + ADDR_W;
  endfunction

endpackage

// File: rtl/grf_trace_collector_if.sv
// Trace-in / record-out bundle of the collector. The slave modport is the
// collector side; the master modport is the producer/consumer side.
interface grf_trace_collector_if
  import grf_trace_collector_pkg::*;
#(
  parameter int AW    = 3,
  parameter int SEQ_W = 16
);
  logic              in_we;
  logic [ADDR_W-1:0] in_addr;
  logic [DATA_W-1:0] in_wdata;
  logic [PC_W-1:0]   in_pc;

  // out_valid/out_ready: a record transfers on any clock edge where both are 1.
  // Once out_valid rises the head fields hold steady until that transfer.
  logic              out_valid;
  logic              out_ready;
  logic [PC_W-1:0]   out_pc;
  logic [ADDR_W-1:0] out_addr;
  logic [DATA_W-1:0] out_wdata;
  logic [SEQ_W-1:0]  out_seq;

  logic [AW:0]       level;
  logic [SEQ_W-1:0]  drop_cnt;
  logic              overflow;

  modport slave (
    input  in_we, in_addr, in_wdata, in_pc, out_ready,
    output out_valid, out_pc, out_addr, out_wdata, out_seq, level, drop_cnt, overflow
  );

  modport master (
    output in_we, in_addr, in_wdata, in_pc, out_ready,
    input  out_valid, out_pc, out_addr, out_wdata, out_seq, level, drop_cnt, overflow
  );
endinterface

// File: rtl/grf_trace_collector_sync_fifo_core.sv
// Show-ahead synchronous FIFO: storage, wrapping pointers and an occupancy
// count that alone distinguishes full from empty.
module grf_trace_collector_sync_fifo_core #(
  parameter int DEPTH = 8,
  parameter int AW    = 3,
  parameter int W     = 85
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_push,
  input  logic          i_pop,
  input  logic [W-1:0]  i_data,
  output logic [W-1:0]  o_data,
  output logic [AW:0]   o_level,
  output logic          o_full,
  output logic          o_empty
);
  localparam logic [AW:0] FULL_LVL = DEPTH[AW:0];

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_level;

  // Storage is deliberately left unreset; only the bookkeeping is cleared.
  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr_ptr] <= i_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (i_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({i_push, i_pop})
        2'b10:   r_level <= r_level + (AW+1)'(1);
        2'b01:   r_level <= r_level - (AW+1)'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  assign o_data  = r_mem[r_rd_ptr];
  assign o_level = r_level;
  assign o_full  = (r_level == FULL_LVL);
  assign o_empty = (r_level == '0);
endmodule

// File: rtl/grf_trace_collector.sv
// Buffers committed GRF writes as sequence-tagged records, counts events lost
// to overflow, and drains records over a valid/ready port.
module grf_trace_collector
  import grf_trace_collector_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int AW    = 3,
  parameter int SEQ_W = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  grf_trace_collector_if.slave  bus
);
  localparam int TW   = trace_w(SEQ_W);
  localparam int O_WD = off_wdata(SEQ_W);
  localparam int O_AD = off_addr(SEQ_W);
  localparam int O_PC = off_pc(SEQ_W);

  logic             w_event;
  logic             w_pop;
  logic             w_push;
  logic             w_drop;
  logic             w_full;
  logic             w_empty;
  logic [TW-1:0]    w_rec;
  logic [TW-1:0]    w_head;
  logic [SEQ_W-1:0] r_seq;
  logic [SEQ_W-1:0] r_drop_cnt;
  logic             r_overflow;

  // Writes to $0 are architectural no-ops and never become events.
  assign w_event = bus.in_we && (bus.in_addr != '0);
  assign w_pop   = !w_empty && bus.out_ready;
  // A full FIFO still accepts an event when the head leaves on the same edge.
  assign w_push  = w_event && (!w_full || w_pop);
  assign w_drop  = w_event && w_full && !w_pop;
  assign w_rec   = {bus.in_pc, bus.in_addr, bus.in_wdata, r_seq};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_seq      <= '0;
      r_drop_cnt <= '0;
      r_overflow <= 1'b0;
    end else begin
      // Dropped events still consume a tag so the consumer sees the gap.
      if (w_event) r_seq <= r_seq + SEQ_W'(1);
      if (w_drop) begin
        r_overflow <= 1'b1;
        if (r_drop_cnt != '1) r_drop_cnt <= r_drop_cnt + SEQ_W'(1);
      end
    end
  end

  grf_trace_collector_sync_fifo_core #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .W     (TW)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (w_rec),
    .o_data  (w_head),
    .o_level (bus.level),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign bus.out_valid = !w_empty;
  assign bus.out_seq   = w_head[SEQ_W-1:0];
  assign bus.out_wdata = w_head[O_WD +: DATA_W];
  assign bus.out_addr  = w_head[O_AD +: ADDR_W];
  assign bus.out_pc    = w_head[O_PC +: PC_W];
  assign bus.drop_cnt  = r_drop_cnt;
  assign bus.overflow  = r_overflow;
endmodule

// File: tb/tb_grf_trace_collector.sv
// Bench for grf_trace_collector: directed vector table, hand-written corner
// sequences and randomized traffic checked against a queue-based model.
module tb_grf_trace_collector;
  localparam int DEPTH = 8;
  localparam int AW    = 3;
  localparam int SEQ_W = 16;
  localparam int W     = 85;  // model record: {seq, pc, addr, wdata}

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  grf_trace_collector_if #(.AW(AW), .SEQ_W(SEQ_W)) bus ();

  grf_trace_collector #(.DEPTH(DEPTH), .AW(AW), .SEQ_W(SEQ_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- scoreboard / model ----------------
  int n_vec  = 0;
  int n_miss = 0;
  logic [W-1:0] exp_q[$];
  logic [15:0]  m_seq;
  logic [15:0]  m_drop;
  logic         m_ovf;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_seq  = 16'd0;
    m_drop = 16'd0;
    m_ovf  = 1'b0;
  endtask

  // One clock edge of the specified behaviour: consumer takes the head first,
  // then the event is stored if room remains, otherwise it is counted as lost.
  task automatic model_edge(input logic we, input logic [4:0] addr, input logic [31:0] wdata,
                            input logic [31:0] pc, input logic rdy);
    if (exp_q.size() != 0 && rdy) void'(exp_q.pop_front());
    if (we && addr != 5'd0) begin
      if (exp_q.size() < DEPTH) exp_q.push_back({m_seq, pc, addr, wdata});
      else begin
        m_ovf = 1'b1;
        if (m_drop != 16'hFFFF) m_drop = m_drop + 16'd1;
      end
      m_seq = m_seq + 16'd1;
    end
  endtask

  task automatic check_model(input string tag);
    logic [W-1:0] head;
    chk({tag, ".valid"}, 64'(bus.out_valid), 64'(exp_q.size() != 0));
    chk({tag, ".level"}, 64'(bus.level), 64'(exp_q.size()));
    chk({tag, ".drop"}, 64'(bus.drop_cnt), 64'(m_drop));
    chk({tag, ".ovf"}, 64'(bus.overflow), 64'(m_ovf));
    if (exp_q.size() != 0) begin
      head = exp_q[0];
      chk({tag, ".seq"}, 64'(bus.out_seq), 64'(head[84:69]));
      chk({tag, ".pc"}, 64'(bus.out_pc), 64'(head[68:37]));
      chk({tag, ".addr"}, 64'(bus.out_addr), 64'(head[36:32]));
      chk({tag, ".wdata"}, 64'(bus.out_wdata), 64'(head[31:0]));
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic apply(input string tag, input logic we, input logic [4:0] addr,
                       input logic [31:0] wdata, input logic [31:0] pc, input logic rdy);
    bus.in_we     = we;
    bus.in_addr   = addr;
    bus.in_wdata  = wdata;
    bus.in_pc     = pc;
    bus.out_ready = rdy;
    @(posedge clk);
    model_edge(we, addr, wdata, pc, rdy);
    #1;
    check_model(tag);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    bus.in_we = 1'b0;
    bus.out_ready = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic       we;
    logic [4:0] addr;
    logic       rdy;
    int         lvl;
    logic [4:0] e_addr;
    int         e_seq;
    int         e_drop;
    logic       e_ovf;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input logic we, input logic [4:0] addr, input logic rdy, input int lvl,
                              input logic [4:0] e_addr, input int e_seq, input int e_drop,
                              input logic e_ovf);
    vec_t v;
    v.we = we; v.addr = addr; v.rdy = rdy; v.lvl = lvl;
    v.e_addr = e_addr; v.e_seq = e_seq; v.e_drop = e_drop; v.e_ovf = e_ovf;
    tbl.push_back(v);
  endfunction

  initial begin
    int rpct;
    logic [31:0] wd;
    logic [31:0] pc;
    logic [4:0]  a;

    bus.in_we = 1'b0; bus.in_addr = '0; bus.in_wdata = '0; bus.in_pc = '0; bus.out_ready = 1'b0;
    model_reset();

    // Table: single event, $0 filter, overflow, full push+pop, drain, tag continuity
    add(1, 5, 0, 1, 5, 0, 0, 0);
    add(0, 0, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) add(1, 0, 0, 0, 0, 0, 0, 0);
    add(1, 7, 0, 1, 7, 1, 0, 0);
    add(0, 0, 1, 0, 0, 0, 0, 0);
    for (int k = 1; k <= 10; k++)
      add(1, 5'(k), 0, (k <= 8) ? k : 8, 5'd1, 2, (k <= 8) ? 0 : k - 8, k > 8);
    add(1, 20, 1, 8, 5'd2, 3, 2, 1);
    for (int j = 1; j <= 8; j++)
      add(0, 0, 1, 8 - j, (j <= 6) ? 5'(2 + j) : 5'd20, (j <= 6) ? 3 + j : 12, 2, 1);
    add(1, 9, 0, 1, 9, 13, 2, 1);
    add(0, 0, 1, 0, 0, 0, 2, 1);

    // Reset values while reset is held
    #1;
    chk("rst.valid", 64'(bus.out_valid), 64'd0);
    chk("rst.level", 64'(bus.level), 64'd0);
    chk("rst.drop", 64'(bus.drop_cnt), 64'd0);
    chk("rst.ovf", 64'(bus.overflow), 64'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      wd = (i == 0) ? 32'h0000_1234 : $urandom;
      pc = (i == 0) ? 32'h0000_3000 : $urandom;
      apply("tbl", tbl[i].we, tbl[i].addr, wd, pc, tbl[i].rdy);
      chk("tbl.valid", 64'(bus.out_valid), 64'(tbl[i].lvl != 0));
      chk("tbl.level", 64'(bus.level), 64'(tbl[i].lvl));
      chk("tbl.drop", 64'(bus.drop_cnt), 64'(tbl[i].e_drop));
      chk("tbl.ovf", 64'(bus.overflow), 64'(tbl[i].e_ovf));
      if (tbl[i].lvl != 0) begin
        chk("tbl.addr", 64'(bus.out_addr), 64'(tbl[i].e_addr));
        chk("tbl.seq", 64'(bus.out_seq), 64'(tbl[i].e_seq));
      end
    end

    // Reset mid-operation: build level 5 with 3 drops, then reset between edges
    do_reset();
    for (int k = 1; k <= 11; k++) apply("fill", 1'b1, 5'(k), $urandom, $urandom, 1'b0);
    for (int k = 0; k < 3; k++) apply("pop3", 1'b0, 5'd0, 32'd0, 32'd0, 1'b1);
    chk("mid.level", 64'(bus.level), 64'd5);
    chk("mid.drop", 64'(bus.drop_cnt), 64'd3);
    @(posedge clk);
    model_edge(1'b0, 5'd0, 32'd0, 32'd0, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    chk("async.valid", 64'(bus.out_valid), 64'd0);
    chk("async.level", 64'(bus.level), 64'd0);
    chk("async.drop", 64'(bus.drop_cnt), 64'd0);
    chk("async.ovf", 64'(bus.overflow), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    model_reset();

    // Back-to-back streaming from an empty FIFO: first tag after reset is 0
    for (int i = 0; i < 20; i++) begin
      apply("stream", 1'b1, 5'($urandom_range(1, 31)), $urandom, $urandom, 1'b1);
      chk("stream.level", 64'(bus.level), 64'd1);
      chk("stream.seq", 64'(bus.out_seq), 64'(i));
      chk("stream.drop", 64'(bus.drop_cnt), 64'd0);
    end

    // Randomized traffic with varying consumer pressure
    for (int ph = 0; ph < 4; ph++) begin
      rpct = (ph == 0) ? 20 : (ph == 1) ? 50 : (ph == 2) ? 90 : 5;
      for (int c = 0; c < 200; c++) begin
        a = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
        apply("rand", $urandom_range(0, 99) < 70, a, $urandom, $urandom,
              $urandom_range(0, 99) < rpct);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
